hdmi_timing_gen: RTL and testbench

Parametrised, runtime-programmable video timing and pixel generator that replaces the fixed-porch `hdmi_core` in `hdmi_out`. It generates hsync/vsync/ve from a register-loaded mode (active size, porches, sync widths, polarities). Pixels come from one of three sources: a solid colour, an 8-bar test pattern, or an external ready/valid pixel stream. It sits between the frame-buffer reader and the HDMI serialiser/PHY wrapper in the pixel-clock domain.

---
 rtl/hdmi_timing_gen.sv | 176 +++++++++++++++++
 tb/tb_hdmi_timing_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hdmi_timing_gen.sv
// Runtime-programmable video timing generator with solid, colour-bar and stream pixel sources.
// Mode and timing are shadowed at start and at each frame end, so mid-frame edits land cleanly.
module hdmi_timing_gen #(
    parameter int H_W = 12,
    parameter int V_W = 11,
    parameter int C_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [H_W-1:0]   hres,
    input  logic [H_W-1:0]   hfp,
    input  logic [H_W-1:0]   hsw,
    input  logic [H_W-1:0]   hbp,
    input  logic [V_W-1:0]   vres,
    input  logic [V_W-1:0]   vfp,
    input  logic [V_W-1:0]   vsw,
    input  logic [V_W-1:0]   vbp,
    input  logic             hsync_pol,
    input  logic             vsync_pol,
    input  logic [1:0]       mode,
    input  logic [3*C_W-1:0] color,
    input  logic [3*C_W-1:0] pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [C_W-1:0]   red,
    output logic [C_W-1:0]   green,
    output logic [C_W-1:0]   blue,
    output logic             hsync,
    output logic             vsync,
    output logic             ve,
    output logic             frame_start,
    output logic             underflow,
    output logic             busy
);
    localparam int HT_W = H_W + 2;
    localparam int VT_W = V_W + 2;

    typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;
    state_t state, state_nxt;

    logic [1:0] rst_pipe;
    logic       rst_int_n;

    logic [H_W-1:0] s_hres, s_hfp, s_hsw, s_hbp;
    logic [V_W-1:0] s_vres, s_vfp, s_vsw, s_vbp;
    logic           s_hpol, s_vpol;
    logic [1:0]     s_mode;

    logic [HT_W-1:0] h, hs_beg, hs_end, htotal;
    logic [VT_W-1:0] v, vs_beg, vs_end, vtotal;
    logic [H_W-1:0]  bar_cnt, bar_w;
    logic [2:0]      bar_idx;

    logic h_last, v_last, frame_end, go, load_cfg, active, hs_act, vs_act, uf_set;
    logic [3*C_W-1:0] rgb_nxt;

    // Assert asynchronously, release on the clock so every flop leaves reset together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_pipe <= '0;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_int_n = rst_pipe[1];

    assign hs_beg = HT_W'(s_hres) + HT_W'(s_hfp);
    assign hs_end = hs_beg + HT_W'(s_hsw);
    assign htotal = hs_end + HT_W'(s_hbp);
    assign vs_beg = VT_W'(s_vres) + VT_W'(s_vfp);
    assign vs_end = vs_beg + VT_W'(s_vsw);
    assign vtotal = vs_end + VT_W'(s_vbp);

    assign busy      = (state != IDLE);
    assign h_last    = (h == htotal - HT_W'(1));
    assign v_last    = (v == vtotal - VT_W'(1));
    assign frame_end = busy && h_last && v_last;
    assign go        = (state == IDLE) && start;
    assign load_cfg  = go || frame_end;
    assign active    = busy && (h < HT_W'(s_hres)) && (v < VT_W'(s_vres));
    assign hs_act    = (h >= hs_beg) && (h < hs_end);
    assign vs_act    = (v >= vs_beg) && (v < vs_end);
    assign pix_ready = active && (s_mode == 2'd2);
    assign bar_w     = s_hres >> 3;

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = RUN;
            RUN: begin
                if (frame_end && stop) state_nxt = IDLE;
                else if (stop)         state_nxt = STOP_PEND;
            end
            STOP_PEND: if (frame_end) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            {s_hres, s_hfp, s_hsw, s_hbp} <= '0;
            {s_vres, s_vfp, s_vsw, s_vbp} <= '0;
            {s_hpol, s_vpol, s_mode}      <= '0;
        end else if (load_cfg) begin
            {s_hres, s_hfp, s_hsw, s_hbp} <= {hres, hfp, hsw, hbp};
            {s_vres, s_vfp, s_vsw, s_vbp} <= {vres, vfp, vsw, vbp};
            {s_hpol, s_vpol, s_mode}      <= {hsync_pol, vsync_pol, mode};
        end
    end

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            h       <= '0;
            v       <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (!busy || h_last) begin
            h       <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
            if (!busy || v_last) v <= '0;
            else                 v <= v + VT_W'(1);
        end else begin
            h <= h + HT_W'(1);
            if (bar_cnt == bar_w - H_W'(1)) begin
                bar_cnt <= '0;
                if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + H_W'(1);
            end
        end
    end

    // Bar order white..black maps to R=~b[1], G=~b[2], B=~b[0].
    always_comb begin
        rgb_nxt = '0;
        uf_set  = 1'b0;
        if (active) begin
            case (s_mode)
                2'd1: rgb_nxt = {{C_W{~bar_idx[1]}}, {C_W{~bar_idx[2]}}, {C_W{~bar_idx[0]}}};
                2'd2: begin
                    if (pix_valid) begin
                        rgb_nxt = pix_data;
                    end else begin
                        rgb_nxt = color;
                        uf_set  = 1'b1;
                    end
                end
                default: rgb_nxt = color;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            {red, green, blue} <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            ve          <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            {red, green, blue} <= rgb_nxt;
            ve          <= active;
            hsync       <= busy ? (hs_act ^ ~s_hpol) : ~hsync_pol;
            vsync       <= busy ? (vs_act ^ ~s_vpol) : ~vsync_pol;
            frame_start <= busy && (h == '0) && (v == '0);
            if (go)          underflow <= 1'b0;
            else if (uf_set) underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Directed bench for hdmi_timing_gen: each run is checked pixel by pixel against a frame model.
module tb_hdmi_timing_gen;
    localparam int H_W = 12;
    localparam int V_W = 11;
    localparam int C_W = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0, stop = 1'b0;
    logic [H_W-1:0] hres, hfp, hsw, hbp;
    logic [V_W-1:0] vres, vfp, vsw, vbp;
    logic hsync_pol, vsync_pol;
    logic [1:0] mode;
    logic [3*C_W-1:0] color, pix_data;
    logic pix_valid = 1'b0;
    logic pix_ready;
    logic [C_W-1:0] red, green, blue;
    logic hsync, vsync, ve, frame_start, underflow, busy;

    int n_assert = 0;
    int n_fail = 0;

    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    int m_hres, m_hfp, m_hsw, m_hbp, m_vres, m_vfp, m_vsw, m_vbp, m_mode;
    logic m_hpol, m_vpol, m_uf;

    always #5 clock = ~clock;

    hdmi_timing_gen #(.H_W(H_W), .V_W(V_W), .C_W(C_W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
        .hres(hres), .hfp(hfp), .hsw(hsw), .hbp(hbp),
        .vres(vres), .vfp(vfp), .vsw(vsw), .vbp(vbp),
        .hsync_pol(hsync_pol), .vsync_pol(vsync_pol), .mode(mode),
        .color(color), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .ve(ve), .frame_start(frame_start),
        .underflow(underflow), .busy(busy)
    );

    function automatic logic [31:0] obs_vec();
        return {2'b00, busy, ve, hsync, vsync, frame_start, underflow, red, green, blue};
    endfunction

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, exp);
        end
    endtask

    task automatic set_cfg(input int hr, input int hf, input int hw, input int hb,
                           input int vr, input int vf, input int vw, input int vb,
                           input logic hp, input logic vp, input int md, input logic [23:0] col);
        hres = H_W'(hr); hfp = H_W'(hf); hsw = H_W'(hw); hbp = H_W'(hb);
        vres = V_W'(vr); vfp = V_W'(vf); vsw = V_W'(vw); vbp = V_W'(vb);
        hsync_pol = hp; vsync_pol = vp; mode = 2'(md); color = col;
    endtask

    task automatic load_model();
        m_hres = int'(hres); m_hfp = int'(hfp); m_hsw = int'(hsw); m_hbp = int'(hbp);
        m_vres = int'(vres); m_vfp = int'(vfp); m_vsw = int'(vsw); m_vbp = int'(vbp);
        m_hpol = hsync_pol; m_vpol = vsync_pol; m_mode = int'(mode);
    endtask

    // Starts from IDLE, checks every registered pixel until the frame carrying the stop ends.
    task automatic run(input string tag, input bit stop_with_start, input int stop_frame,
                       input int stop_fp, input int chg_fp, input int chg_hres);
        int frame, fp, h, v, htot, vtot, ftot, bi;
        logic act, hs, vs, pv, last;
        logic [23:0] rgb, pd;
        bit done;
        load_model();
        m_uf = 1'b0;
        start = 1'b1;
        stop = stop_with_start;
        @(negedge clock);
        start = 1'b0;
        stop = 1'b0;
        chk({tag, "_e0"}, 0, obs_vec(), {2'b00, 1'b1, 1'b0, ~hsync_pol, ~vsync_pol, 1'b0, 1'b0, 24'h0});
        frame = 0;
        fp = 0;
        done = 1'b0;
        for (int p = 0; p < 2000 && !done; p++) begin
            htot = m_hres + m_hfp + m_hsw + m_hbp;
            vtot = m_vres + m_vfp + m_vsw + m_vbp;
            ftot = htot * vtot;
            h = fp % htot;
            v = fp / htot;
            act = (h < m_hres) && (v < m_vres);
            if (frame == 0 && fp == chg_fp) hres = H_W'(chg_hres);
            stop = (frame == stop_frame) && (fp == stop_fp);
            pv = !(m_mode == 2 && frame == 0 && h == 3 && v == 1);
            pd = 24'(p * 66051 + 1193046);
            pix_valid = pv;
            pix_data = pd;
            #1;
            chk({tag, "_ready"}, p, 32'(pix_ready), 32'(act && m_mode == 2));
            if (!act) rgb = 24'h0;
            else if (m_mode == 1) begin
                bi = h / (m_hres / 8);
                if (bi > 7) bi = 7;
                rgb = bar_tab[bi];
            end else if (m_mode == 2 && pv) rgb = pd;
            else rgb = color;
            if (act && m_mode == 2 && !pv) m_uf = 1'b1;
            hs = ((h >= m_hres + m_hfp) && (h < m_hres + m_hfp + m_hsw)) ^ ~m_hpol;
            vs = ((v >= m_vres + m_vfp) && (v < m_vres + m_vfp + m_vsw)) ^ ~m_vpol;
            last = (frame == stop_frame) && (fp == ftot - 1);
            @(negedge clock);
            chk(tag, p, obs_vec(), {2'b00, ~last, act, hs, vs, (h == 0 && v == 0), m_uf, rgb});
            fp++;
            if (fp == ftot) begin
                fp = 0;
                frame++;
                load_model();
                if (last) done = 1'b1;
            end
        end
        n_assert++;
        assert (done) else begin
            n_fail++;
            $error("FAIL %s_end: observed no frame end within bound, expected return to IDLE", tag);
        end
        stop = 1'b0;
        pix_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk({tag, "_idle"}, i, obs_vec(), {2'b00, 1'b0, 1'b0, ~hsync_pol, ~vsync_pol, 1'b0, m_uf, 24'h0});
            chk({tag, "_idle_ready"}, i, 32'(pix_ready), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no completion, expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_cfg(8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b1, 0, 24'hFF8000);
        repeat (2) @(negedge clock);
        chk("reset_outputs", 0, obs_vec(), 32'h0);
        chk("reset_ready", 0, 32'(pix_ready), 32'd0);

        hsync_pol = 1'b0;
        vsync_pol = 1'b0;
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        chk("idle_pol0", 0, obs_vec(), {2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0});
        hsync_pol = 1'b1;
        vsync_pol = 1'b1;
        @(negedge clock);
        chk("idle_pol1", 0, obs_vec(), 32'h0);

        // Two frames, stop requested at h=5,v=2 of the second.
        run("solid_pol1", 1'b0, 1, 33, -1, 0);

        set_cfg(8, 2, 3, 1, 4, 1, 2, 1, 1'b0, 1'b0, 0, 24'hFF8000);
        run("solid_pol0", 1'b1, 0, 50, -1, 0);

        set_cfg(8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b1, 2, 24'h123456);
        run("stream", 1'b0, 0, 0, -1, 0);

        set_cfg(16, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b1, 1, 24'h0);
        run("bars", 1'b0, 0, 0, -1, 0);

        set_cfg(8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b1, 0, 24'h00C0FF);
        run("hres_change", 1'b0, 1, 0, 40, 12);

        set_cfg(8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b1, 0, 24'hFF8000);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("pre_reset_ve", 0, 32'(ve), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", 0, obs_vec(), 32'h0);
        chk("async_reset_ready", 0, 32'(pix_ready), 32'd0);
        @(negedge clock);
        chk("reset_held", 0, obs_vec(), 32'h0);
        hsync_pol = 1'b0;
        vsync_pol = 1'b0;
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        chk("after_reset_idle", 0, obs_vec(), {2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0});
        chk("after_reset_ready", 0, 32'(pix_ready), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
